// File: rtl/cluster_seed_count.sv
// cluster_seed_count
//   Per-pad cluster seed detector and size counter for the GEM S-bit cluster
//   packer. One instance sits on each S-bit pad i. It decides whether pad i
//   starts a cluster, either at the bottom of a run or as a split seed every
//   MXCNT+1 pads inside a long run. It also counts the consecutive set pads
//   above i, saturating at MXCNT.
//
// Optional feature macro: CLUSTER_SEED_HITCNT_EN
//   When it is defined, hit_cnt is a saturating count of clocks on which the
//   registered valid is 1. When it is undefined, hit_cnt is tied to 0.
//
// Parameters
//   MXCNT   max additional pads counted after the seed (cluster size 1..MXCNT+1)
//   CNTB    count width, 2**CNTB > MXCNT
//   MXSPLIT max split segments recognised below pad i in one run
//   PIPE    latency in clocks, 1 or 2
//   HITW    hit-counter width
//
// Ports
//   clock    system clock
//   reset    synchronous active-high reset, clears every register
//   en       window-valid qualifier
//   sbit_i   S-bit of pad i
//   win_lo   pads i-1 (bit0) down to i-LB (bit LB-1)
//   win_hi   pads i+1 (bit0) up to i+MXCNT+1 (bit MXCNT)
//   valid    pad i is a cluster seed
//   cnt      consecutive set pads after i (cluster size = cnt+1)
//   trunc    run continues past this cluster; the next segment re-seeds
//   hit_cnt  saturating seed count (feature only, else 0)
module cluster_seed_count #(
  parameter int MXCNT   = 7,
  parameter int CNTB    = 3,
  parameter int MXSPLIT = 1,
  parameter int PIPE    = 1,
  parameter int HITW    = 16,
  localparam int LB     = MXSPLIT * (MXCNT + 1) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             sbit_i,
  input  logic [LB-1:0]    win_lo,
  input  logic [MXCNT:0]   win_hi,
  output logic             valid,
  output logic [CNTB-1:0]  cnt,
  output logic             trunc,
  output logic [HITW-1:0]  hit_cnt
);

  // Pad i is a seed when the run of ones directly below it has a length that
  // is a multiple of MXCNT+1, and a terminating zero lies inside the window.
  // Each candidate position b = k*(MXCNT+1) matches when every bit below b is
  // 1 and bit b is 0. If win_lo is all ones, no position matches, so pad i is
  // interior to the run and is not a seed.
  function automatic logic seed_run(input logic [LB-1:0] lo);
    logic ok;
    logic pre;
    ok  = 1'b0;
    pre = 1'b1;
    for (int b = 0; b < LB; b++) begin
      if (b % (MXCNT + 1) == 0) ok = ok | (pre & ~lo[b]);
      pre = pre & lo[b];
    end
    return ok;
  endfunction

  // Leading-ones length found by first-zero priority detection rather than an
  // adder chain. If no zero is found, the result is MXCNT.
  function automatic logic [CNTB-1:0] lead_ones(input logic [MXCNT-1:0] hi);
    logic [CNTB-1:0] c;
    c = CNTB'(MXCNT);
    for (int j = MXCNT - 1; j >= 0; j--) begin
      if (!hi[j]) c = CNTB'(j);
    end
    return c;
  endfunction

  // Saturating increment: the value holds at its maximum and never wraps.
  function automatic logic [HITW-1:0] sat_inc(input logic [HITW-1:0] v);
    return (&v) ? v : v + HITW'(1);
  endfunction

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("cluster_seed_count: PIPE must be 1 or 2");
  end
  if ((2 ** CNTB) <= MXCNT || MXCNT < 1) begin : g_bad_cntb
    $error("cluster_seed_count: need MXCNT >= 1 and 2**CNTB > MXCNT");
  end

  logic            seed_c;
  logic            full_c;
  logic            vld_p1;
  logic [CNTB-1:0] cnt_p1;
  logic            trunc_p1;

  assign seed_c = en & sbit_i & seed_run(win_lo);
  // The count reaches MXCNT with bit MXCNT also set exactly when the whole
  // upper window is ones. That is the trunc pre-term.
  assign full_c = &win_hi;

  if (PIPE == 2) begin : g_pipe2
    logic             vld_p0;
    logic [MXCNT-1:0] hi_p0;
    logic             full_p0;

    // ---- stage 0: seed decision, upper window copy, trunc pre-term ----
    always_ff @(posedge clock) begin
      if (reset) begin
        vld_p0  <= 1'b0;
        hi_p0   <= '0;
        full_p0 <= 1'b0;
      end else begin
        vld_p0  <= seed_c;
        hi_p0   <= win_hi[MXCNT-1:0];
        full_p0 <= full_c;
      end
    end

    // ---- stage 1: count, valid, trunc ----
    always_ff @(posedge clock) begin
      if (reset) begin
        vld_p1   <= 1'b0;
        cnt_p1   <= '0;
        trunc_p1 <= 1'b0;
      end else begin
        vld_p1   <= vld_p0;
        cnt_p1   <= vld_p0 ? lead_ones(hi_p0) : '0;
        trunc_p1 <= vld_p0 & full_p0;
      end
    end
  end else begin : g_pipe1
    // ---- stage 1: seed and count straight into the output register ----
    always_ff @(posedge clock) begin
      if (reset) begin
        vld_p1   <= 1'b0;
        cnt_p1   <= '0;
        trunc_p1 <= 1'b0;
      end else begin
        vld_p1   <= seed_c;
        cnt_p1   <= seed_c ? lead_ones(win_hi[MXCNT-1:0]) : '0;
        trunc_p1 <= seed_c & full_c;
      end
    end
  end

  assign valid = vld_p1;
  assign cnt   = cnt_p1;
  assign trunc = trunc_p1;

`ifdef CLUSTER_SEED_HITCNT_EN
  logic [HITW-1:0] hit_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q <= '0;
    end else if (vld_p1) begin
      hit_q <= sat_inc(hit_q);
    end
  end

  assign hit_cnt = hit_q;
`else
  assign hit_cnt = '0;
`endif

endmodule
